pipe_reg_file: RTL and testbench

//  Parametrised multi-port register file with a write-pending scoreboard for the pipelined CPU.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/rf_scoreboard.sv | 63 ++++++
 rtl/pipe_reg_file.sv | 96 +++++++++
 tb/tb_pipe_reg_file.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file constants and the byte-enable merge helper used by the CPU datapath.
package cpu_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Widest word the merge helper handles; narrower callers zero-pad into it.
  localparam int MERGE_W = 256;

  function automatic logic [MERGE_W-1:0] be_merge(input logic [MERGE_W-1:0]   old_w,
                                                  input logic [MERGE_W-1:0]   new_w,
                                                  input logic [MERGE_W/8-1:0] be);
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int b = 0; b < MERGE_W / 8; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set at issue and cleared at write-back.
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic                     w0_en,
  input  logic [ADDR_W-1:0]        w0_addr,
  input  logic                     w1_en,
  input  logic [ADDR_W-1:0]        w1_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) cnt = cnt + (ADDR_W + 1)'(v[k]);
    return cnt;
  endfunction

  // Clear first, then set, so a new producer issuing in the write-back cycle keeps the bit.
  always_comb begin
    busy_nxt = busy;
    if (w0_en) busy_nxt[w0_addr] = 1'b0;
    if (w1_en) busy_nxt[w1_addr] = 1'b0;
    if (iss_en && !((ZERO_REG != 0) && (iss_addr == '0))) busy_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

  // A register written this cycle has valid bypassed data, so it is not reported busy.
  always_comb begin
    logic [ADDR_W-1:0] a;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = rd_addr[i*ADDR_W +: ADDR_W];
      rd_busy[i] = !rst && busy[a] &&
                   !((w0_en && (w0_addr == a)) || (w1_en && (w1_addr == a)));
    end
  end

endmodule

// File: rtl/pipe_reg_file.sv
// Multi-port CPU register file: byte-enabled ALU write-back, full-word MEM/MDU write-back,
// same-cycle bypass on every read port, and a busy scoreboard for hazard detection.
module pipe_reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     w0_en,
  input  logic [ADDR_W-1:0]        w0_addr,
  input  logic [DATA_W/8-1:0]      w0_be,
  input  logic [DATA_W-1:0]        w0_data,
  input  logic                     w1_en,
  input  logic [ADDR_W-1:0]        w1_addr,
  input  logic [DATA_W-1:0]        w1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] regs [DEPTH];

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [NB-1:0]     be);
    logic [MERGE_W-1:0]   o;
    logic [MERGE_W-1:0]   n;
    logic [MERGE_W-1:0]   r;
    logic [MERGE_W/8-1:0] b;
    o = '0;
    n = '0;
    b = '0;
    o[DATA_W-1:0] = old_w;
    n[DATA_W-1:0] = new_w;
    b[NB-1:0]     = be;
    r = be_merge(o, n, b);
    return r[DATA_W-1:0];
  endfunction

  // w1 is applied last so it wins every byte when both ports hit the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      if (w0_en && !is_zero(w0_addr)) regs[w0_addr] <= merge(regs[w0_addr], w0_data, w0_be);
      if (w1_en && !is_zero(w1_addr)) regs[w1_addr] <= w1_data;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = rd_addr[i*ADDR_W +: ADDR_W];
      v = regs[a];
      if (w0_en && (w0_addr == a)) v = merge(v, w0_data, w0_be);
      if (w1_en && (w1_addr == a)) v = w1_data;
      if (rst || is_zero(a)) v = '0;
      rd_data[i*DATA_W +: DATA_W] = v;
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .w0_en   (w0_en),
    .w0_addr (w0_addr),
    .w1_en   (w1_en),
    .w1_addr (w1_addr),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .rd_busy (rd_busy),
    .busy_cnt(busy_cnt)
  );

endmodule

// File: tb/tb_pipe_reg_file.sv
// Directed bench for pipe_reg_file with default parameters (32-bit, 32 regs, 2 read ports, r0 = 0).
module tb_pipe_reg_file;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        w0_en;
  logic [4:0]  w0_addr;
  logic [3:0]  w0_be;
  logic [31:0] w0_data;
  logic        w1_en;
  logic [4:0]  w1_addr;
  logic [31:0] w1_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [5:0]  busy_cnt;

  int n_cmp;
  int n_fail;

  pipe_reg_file dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .w0_en   (w0_en),
    .w0_addr (w0_addr),
    .w0_be   (w0_be),
    .w0_data (w0_data),
    .w1_en   (w1_en),
    .w1_addr (w1_addr),
    .w1_data (w1_data),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; w0_en = 1'b0; w1_en = 1'b0; iss_en = 1'b0;
    w0_addr = '0; w0_be = '0; w0_data = '0;
    w1_addr = '0; w1_data = '0; iss_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; w0_en = 1'b1; w0_addr = 5'd5; w0_be = 4'hF; w0_data = 32'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 5'd5; rd_addr = {5'd5, 5'd5};
    #1;
    n_cmp++;
    if (rd_data !== 64'h0) begin n_fail++; $display("FAIL rst_rd_data got %h exp %h", rd_data, 64'h0); end
    n_cmp++;
    if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL rst_rd_busy got %b exp %b", rd_busy, 2'b00); end
    tick();
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL reset_r5 got %h exp %h", rd_data[31:0], 32'h0); end
    n_cmp++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_busy_cnt got %0d exp %0d", busy_cnt, 0); end
    n_cmp++;
    if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_r5_busy got %b exp %b", rd_busy, 2'b00); end
  endtask

  task automatic test_byte_enable();
    w1_en = 1'b1; w1_addr = 5'd3; w1_data = 32'h11223344;
    tick();
    idle();
    w0_en = 1'b1; w0_addr = 5'd3; w0_be = 4'b0101; w0_data = 32'hAABBCCDD;
    rd_addr = {5'd0, 5'd3};
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_bypass got %h exp %h", rd_data[31:0], 32'h11BB33DD); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_stored got %h exp %h", rd_data[31:0], 32'h11BB33DD); end
  endtask

  task automatic test_conflict();
    w0_en = 1'b1; w0_addr = 5'd7; w0_be = 4'hF; w0_data = 32'h1;
    w1_en = 1'b1; w1_addr = 5'd7; w1_data = 32'h2;
    rd_addr = {5'd7, 5'd7};
    #1;
    n_cmp++;
    if (rd_data !== {32'h2, 32'h2}) begin n_fail++; $display("FAIL conflict_bypass got %h exp %h", rd_data, {32'h2, 32'h2}); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[63:32] !== 32'h2) begin n_fail++; $display("FAIL conflict_stored got %h exp %h", rd_data[63:32], 32'h2); end
  endtask

  task automatic test_zero_reg();
    w1_en = 1'b1; w1_addr = 5'd0; w1_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL zero_bypass got %h exp %h", rd_data[31:0], 32'h0); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL zero_stored got %h exp %h", rd_data[31:0], 32'h0); end
    n_cmp++;
    if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL zero_busy got %b exp %b", rd_busy, 2'b00); end
    n_cmp++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL zero_busy_cnt got %0d exp %0d", busy_cnt, 0); end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 5'd9;
    rd_addr = {5'd8, 5'd9};
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL iss_same_cycle got %b exp %b", rd_busy[0], 1'b0); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy !== 2'b01) begin n_fail++; $display("FAIL iss_busy got %b exp %b", rd_busy, 2'b01); end
    n_cmp++;
    if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL iss_busy_cnt got %0d exp %0d", busy_cnt, 1); end
    w0_en = 1'b1; w0_addr = 5'd9; w0_be = 4'hF; w0_data = 32'h99;
    iss_en = 1'b1; iss_addr = 5'd9;
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL wb_unbusy got %b exp %b", rd_busy[0], 1'b0); end
    n_cmp++;
    if (rd_data[31:0] !== 32'h99) begin n_fail++; $display("FAIL wb_bypass got %h exp %h", rd_data[31:0], 32'h99); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL set_wins got %b exp %b", rd_busy[0], 1'b1); end
    n_cmp++;
    if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL set_wins_cnt got %0d exp %0d", busy_cnt, 1); end
    // Re-issue to a busy register keeps it busy without double counting.
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    #1;
    n_cmp++;
    if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL reissue_cnt got %0d exp %0d", busy_cnt, 1); end
    w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'h5;
    tick();
    idle();
    #1;
    n_cmp++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL w1_clear_cnt got %0d exp %0d", busy_cnt, 0); end
    n_cmp++;
    if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL w1_clear_busy got %b exp %b", rd_busy[0], 1'b0); end
  endtask

  task automatic test_back_to_back();
    w0_en = 1'b1; w0_addr = 5'd12; w0_be = 4'hF; w0_data = 32'h01020304;
    tick();
    w0_be = 4'b1000; w0_data = 32'hFF000000;
    rd_addr = {5'd12, 5'd12};
    #1;
    n_cmp++;
    if (rd_data[31:0] !== 32'hFF020304) begin n_fail++; $display("FAIL b2b_bypass got %h exp %h", rd_data[31:0], 32'hFF020304); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[63:32] !== 32'hFF020304) begin n_fail++; $display("FAIL b2b_stored got %h exp %h", rd_data[63:32], 32'hFF020304); end
  endtask

  task automatic test_reset_mid();
    for (int r = 1; r <= 4; r++) begin
      iss_en = 1'b1; iss_addr = 5'(r);
      tick();
    end
    idle();
    rd_addr = {5'd2, 5'd1};
    #1;
    n_cmp++;
    if (busy_cnt !== 6'd4) begin n_fail++; $display("FAIL pre_rst_cnt got %0d exp %0d", busy_cnt, 4); end
    n_cmp++;
    if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL pre_rst_busy got %b exp %b", rd_busy, 2'b11); end
    rst = 1'b1;
    rd_addr = {5'd12, 5'd3};
    #1;
    n_cmp++;
    if (rd_data !== 64'h0) begin n_fail++; $display("FAIL in_rst_data got %h exp %h", rd_data, 64'h0); end
    tick();
    idle();
    #1;
    n_cmp++;
    if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL post_rst_cnt got %0d exp %0d", busy_cnt, 0); end
    n_cmp++;
    if (rd_data !== 64'h0) begin n_fail++; $display("FAIL post_rst_data got %h exp %h", rd_data, 64'h0); end
    for (int r = 1; r <= 4; r += 2) begin
      rd_addr = {5'(r + 1), 5'(r)};
      #1;
      n_cmp++;
      if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL post_rst_busy r%0d got %b exp %b", r, rd_busy, 2'b00); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    idle();
    rd_addr = '0;
    test_reset();
    test_byte_enable();
    test_conflict();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
